// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
`default_nettype none

package muldiv_ctrl_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } md_state_t;

  typedef struct packed {
    word_t  a;
    word_t  b;
    md_op_t op;
    logic   unsign;
    logic   word;
  } md_req_t;

  // Datapath iteration counts (cycles dp_busy stays high after dp_en rises).
  localparam int N_MUL   = 16;
  localparam int N_MUL_W = 8;
  localparam int N_DIV   = 64;
  localparam int N_DIV_W = 32;

  function automatic int md_latency(input md_op_t op, input logic word);
    if (op == MD_MUL) return word ? N_MUL_W : N_MUL;
    return word ? N_DIV_W : N_DIV;
  endfunction

  function automatic word_t sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_result_cache.sv
// Single-entry result cache keyed on the full request (operands and control).
`default_nettype none

module md_result_cache
  import muldiv_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    wr_en,
  input  md_req_t wr_key,
  input  word_t   wr_data,
  input  md_req_t rd_key,
  output logic    hit,
  output word_t   rd_data
);

  logic    valid;
  md_req_t key;
  word_t   data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      key   <= '0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      key   <= wr_key;
      data  <= wr_data;
    end
  end

  assign hit     = valid && (key == rd_key);
  assign rd_data = data;

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide datapath: request
// latch, divide-by-zero and repeat-request fast paths, registered response.
`default_nettype none

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   req_valid,
  output logic   req_ready,
  input  word_t  req_a,
  input  word_t  req_b,
  input  md_op_t req_op,
  input  logic   req_unsign,
  input  logic   req_word,
  output logic   resp_valid,
  input  logic   resp_ready,
  output word_t  resp_data,
  output logic   dp_en,
  output word_t  dp_a,
  output word_t  dp_b,
  output md_op_t dp_op,
  output logic   dp_unsign,
  output logic   dp_word,
  input  logic   dp_busy,
  input  word_t  dp_data
);

  md_state_t state;
  md_req_t   cur;
  md_req_t   req_in;
  logic      accept;
  logic      div_zero;
  word_t     zero_res;
  logic      cache_hit;
  word_t     cache_data;
  logic      capture;

  assign req_in = '{a: req_a, b: req_b, op: req_op, unsign: req_unsign, word: req_word};

  assign req_ready = (state == IDLE) && !flush;
  assign dp_en     = (state == RUN) && !flush;
  assign accept    = req_valid && req_ready;
  assign capture   = dp_en && !dp_busy;

  // Word variants only look at the low 32 bits of the divisor.
  assign div_zero = (req_op != MD_MUL) &&
                    (req_word ? (req_b[31:0] == 32'd0) : (req_b == 64'd0));
  assign zero_res = (req_op == MD_DIV) ? '1 :
                    (req_word ? sext32(req_a[31:0]) : req_a);

  md_result_cache u_cache (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_key  (cur),
    .wr_data (dp_data),
    .rd_key  (req_in),
    .hit     (cache_hit),
    .rd_data (cache_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur <= req_in;
            if (div_zero) begin
              resp_data  <= zero_res;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (cache_hit) begin
              resp_data  <= cache_data;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else if (!dp_busy) begin
            resp_data  <= dp_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          // A flush coinciding with resp_ready still counts as a dropped result.
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign dp_a      = cur.a;
  assign dp_b      = cur.b;
  assign dp_op     = cur.op;
  assign dp_unsign = cur.unsign;
  assign dp_word   = cur.word;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with a behavioural iterative datapath.
`default_nettype none

module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   flush;
  logic   req_valid;
  logic   req_ready;
  word_t  req_a, req_b;
  md_op_t req_op;
  logic   req_unsign, req_word;
  logic   resp_valid;
  logic   resp_ready;
  word_t  resp_data;
  logic   dp_en;
  word_t  dp_a, dp_b;
  md_op_t dp_op;
  logic   dp_unsign, dp_word;
  logic   dp_busy;
  word_t  dp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_unsign(req_unsign), .req_word(req_word),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .dp_unsign(dp_unsign), .dp_word(dp_word),
    .dp_busy(dp_busy), .dp_data(dp_data)
  );

  // Behavioural datapath: busy for N cycles after dp_en rises, then result final.
  int dp_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset)                               dp_cnt <= 0;
    else if (!dp_en)                          dp_cnt <= 0;
    else if (dp_cnt < md_latency(dp_op, dp_word)) dp_cnt <= dp_cnt + 1;
  end
  assign dp_busy = dp_en && (dp_cnt < md_latency(dp_op, dp_word));

  always_comb begin
    logic [31:0] a32, b32, r32;
    word_t r64;
    a32 = dp_a[31:0];
    b32 = dp_b[31:0];
    r32 = '0;
    r64 = '0;
    dp_data = '0;
    case (dp_op)
      MD_MUL: begin
        r64 = dp_a * dp_b;
        r32 = a32 * b32;
      end
      MD_DIV: begin
        r64 = dp_unsign ? dp_a / dp_b : word_t'($signed(dp_a) / $signed(dp_b));
        r32 = dp_unsign ? a32 / b32 : 32'($signed(a32) / $signed(b32));
      end
      default: begin
        r64 = dp_unsign ? dp_a % dp_b : word_t'($signed(dp_a) % $signed(dp_b));
        r32 = dp_unsign ? a32 % b32 : 32'($signed(a32) % $signed(b32));
      end
    endcase
    dp_data = dp_word ? {{32{r32[31]}}, r32} : r64;
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its response; returns at the negedge of
  // the first cycle with resp_valid high, without consuming it.
  task automatic run_req(input word_t a, input word_t b, input md_op_t op,
                         input logic u, input logic w,
                         output int lat, output int en_cnt, output word_t data);
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_unsign = u; req_word = w;
    req_valid = 1'b1;
    chk("req_ready_before_accept", word_t'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    en_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (dp_en) en_cnt++;
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout actual=%0d required=response", lat);
    end
    data = resp_data;
    chk("dp_a_latched", dp_a, a);
    chk("dp_b_latched", dp_b, b);
  endtask

  typedef struct {
    word_t  a;
    word_t  b;
    md_op_t op;
    logic   u;
    logic   w;
    word_t  exp;
    int     lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat, en_cnt, seen;
    word_t data;

    vecs[0]  = '{64'd7, 64'd6, MD_MUL, 1'b1, 1'b0, 64'd42, 18};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFEC, 64'd3, MD_DIV, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 34};
    vecs[2]  = '{64'h1_8000_0001, 64'd0, MD_REM, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0001, 1};
    vecs[3]  = '{64'd5, 64'd0, MD_DIV, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[4]  = '{64'd100, 64'd7, MD_DIV, 1'b0, 1'b0, 64'd14, 66};
    vecs[5]  = '{64'd100, 64'd7, MD_DIV, 1'b0, 1'b0, 64'd14, 1};
    vecs[6]  = '{64'd100, 64'd8, MD_DIV, 1'b0, 1'b0, 64'd12, 66};
    vecs[7]  = '{64'd100, 64'd7, MD_REM, 1'b0, 1'b0, 64'd2, 66};
    vecs[8]  = '{64'h1_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, MD_MUL, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 10};
    vecs[9]  = '{64'd9, 64'h1_0000_0000, MD_DIV, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[10] = '{64'h2_0000_0000, 64'h1_0000_0000, MD_DIV, 1'b1, 1'b0, 64'd2, 66};
    vecs[11] = '{64'h1234, 64'd0, MD_REM, 1'b0, 1'b0, 64'h1234, 1};
    vecs[12] = '{64'h2_0000_0000, 64'h1_0000_0000, MD_DIV, 1'b1, 1'b0, 64'd2, 1};

    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_a = '0; req_b = '0; req_op = MD_MUL; req_unsign = 1'b0; req_word = 1'b0;
    #2;
    chk("rst_resp_valid", word_t'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_dp_en", word_t'(dp_en), 64'd0);
    chk("rst_dp_a", dp_a, 64'd0);
    chk("rst_dp_ctrl", word_t'({dp_op, dp_unsign, dp_word}), 64'd0);
    chk("rst_req_ready", word_t'(req_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].u, vecs[i].w, lat, en_cnt, data);
      chk($sformatf("v%0d_data", i), data, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), word_t'(lat), word_t'(vecs[i].lat));
      chk($sformatf("v%0d_dp_en_cycles", i), word_t'(en_cnt),
          word_t'(vecs[i].lat == 1 ? 0 : vecs[i].lat - 1));
    end

    // Flush at T+10 of a 64-bit DIV.
    @(negedge clk);
    req_a = 64'd100; req_b = 64'd9; req_op = MD_DIV; req_unsign = 1'b0; req_word = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_dp_en_before", word_t'(dp_en), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_dp_en_comb_low", word_t'(dp_en), 64'd0);
    chk("flush_req_ready_low", word_t'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid || dp_en) seen++;
    end
    chk("flush_no_response", word_t'(seen), 64'd0);

    // Pre-flush cache entry must survive the flush.
    run_req(64'h2_0000_0000, 64'h1_0000_0000, MD_DIV, 1'b1, 1'b0, lat, en_cnt, data);
    chk("post_flush_hit_data", data, 64'd2);
    chk("post_flush_hit_latency", word_t'(lat), 64'd1);
    run_req(64'd3, 64'd3, MD_MUL, 1'b0, 1'b0, lat, en_cnt, data);
    chk("mul3x3_data", data, 64'd9);
    chk("mul3x3_latency", word_t'(lat), 64'd18);
    run_req(64'd100, 64'd9, MD_DIV, 1'b0, 1'b0, lat, en_cnt, data);
    chk("flushed_req_not_cached_data", data, 64'd11);
    chk("flushed_req_not_cached_latency", word_t'(lat), 64'd66);

    // Back-pressure: resp_ready low for 5 cycles in RESP.
    @(negedge clk);
    resp_ready = 1'b0;
    run_req(64'd5, 64'd5, MD_MUL, 1'b1, 1'b0, lat, en_cnt, data);
    chk("bp_data", data, 64'd25);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== 64'd25 || req_ready || dp_en) seen++;
    end
    chk("bp_hold_stable", word_t'(seen), 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", word_t'(resp_valid), 64'd0);
    chk("bp_idle_ready", word_t'(req_ready), 64'd1);

    // Flush and resp_ready together in RESP: response dropped, back to IDLE.
    resp_ready = 1'b0;
    run_req(64'd5, 64'd5, MD_MUL, 1'b1, 1'b0, lat, en_cnt, data);
    chk("flush_resp_hit_latency", word_t'(lat), 64'd1);
    flush = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_resp_dropped", word_t'(resp_valid), 64'd0);
    chk("flush_resp_idle", word_t'(req_ready), 64'd1);

    // Reset mid-RUN.
    @(negedge clk);
    req_a = 64'd11; req_b = 64'd11; req_op = MD_MUL; req_unsign = 1'b0; req_word = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_dp_en", word_t'(dp_en), 64'd0);
    chk("midrst_resp_valid", word_t'(resp_valid), 64'd0);
    chk("midrst_resp_data", resp_data, 64'd0);
    chk("midrst_dp_a", dp_a, 64'd0);
    chk("midrst_dp_b", dp_b, 64'd0);
    chk("midrst_req_ready", word_t'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    // Cache cleared by reset: a previously cached request takes full latency.
    run_req(64'd5, 64'd5, MD_MUL, 1'b1, 1'b0, lat, en_cnt, data);
    chk("after_rst_data", data, 64'd25);
    chk("after_rst_latency", word_t'(lat), 64'd18);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
